// File: rtl/flag_register.sv
// ALU adder/subtractor with a registered NZCV flag file, a two-state validity
// FSM and a saturating count of committed flag writes.
module flag_register #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             subtract,
  input  logic             set_flags,
  input  logic             stall,
  input  logic             clear,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             flags_valid,
  output logic [7:0]       write_count
);

  typedef enum logic {EMPTY, VALID} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             n_next, z_next, c_next, v_next;
  logic             commit, do_clear;

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  endfunction

  // Subtraction is a + ~b + 1, so carry-out means "no borrow".
  always_comb begin
    b_eff  = subtract ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, subtract};
    result = sum[WIDTH-1:0];
    n_next = sum[WIDTH-1];
    z_next = (sum[WIDTH-1:0] == '0);
    c_next = sum[WIDTH];
    v_next = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

  // A stall freezes everything, and clear outranks a flag-setting instruction.
  assign do_clear = clear & ~stall;
  assign commit   = set_flags & ~stall & ~clear;

  always_comb begin
    state_next = state;
    if (do_clear)
      state_next = EMPTY;
    else if (commit)
      state_next = VALID;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= EMPTY;
    else
      state <= state_next;
  end

  assign flags_valid = (state == VALID);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      negative    <= 1'b0;
      zero        <= 1'b0;
      carry       <= 1'b0;
      overflow    <= 1'b0;
      write_count <= 8'd0;
    end else if (do_clear) begin
      negative    <= 1'b0;
      zero        <= 1'b0;
      carry       <= 1'b0;
      overflow    <= 1'b0;
      write_count <= 8'd0;
    end else if (commit) begin
      negative    <= n_next;
      zero        <= z_next;
      carry       <= c_next;
      overflow    <= v_next;
      write_count <= sat_inc(write_count);
    end
  end

endmodule

// File: tb/tb_flag_register.sv
// Randomized and directed bench for flag_register against an arithmetic
// reference model of the flags, validity and write counter.
module tb_flag_register;
  localparam int W = 64;

  logic         clk, reset;
  logic [W-1:0] a, b, result;
  logic         subtract, set_flags, stall, clear;
  logic         negative, zero, carry, overflow, flags_valid;
  logic [7:0]   write_count;
  logic [12:0]  obs;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state
  logic [3:0] m_nzcv;
  logic       m_valid;
  int         m_cnt;

  flag_register #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .subtract(subtract),
    .set_flags(set_flags), .stall(stall), .clear(clear), .result(result),
    .negative(negative), .zero(zero), .carry(carry), .overflow(overflow),
    .flags_valid(flags_valid), .write_count(write_count)
  );

  assign obs = {negative, zero, carry, overflow, flags_valid, write_count};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_result(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic sub);
    return sub ? x - y : x + y;
  endfunction

  // Flags from plain unsigned/signed arithmetic on wider values.
  function automatic logic [3:0] ref_nzcv(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic sub);
    logic [W:0]          uw;
    logic signed [W+1:0] sx, sy, s;
    logic [W-1:0]        r;
    logic                c, v;
    sx = $signed({{2{x[W-1]}}, x});
    sy = $signed({{2{y[W-1]}}, y});
    if (sub) begin
      r = x - y;
      c = (x >= y);
      s = sx - sy;
    end else begin
      uw = {1'b0, x} + {1'b0, y};
      r  = uw[W-1:0];
      c  = uw[W];
      s  = sx + sy;
    end
    v = (s != $signed({{2{r[W-1]}}, r}));
    return {r[W-1], (r == '0), c, v};
  endfunction

  function automatic logic [12:0] mdl_vec();
    logic [7:0] c8;
    c8 = m_cnt[7:0];
    return {m_nzcv, m_valid, c8};
  endfunction

  task automatic mdl_reset();
    m_nzcv  = 4'b0000;
    m_valid = 1'b0;
    m_cnt   = 0;
  endtask

  // Advance the model with the currently driven inputs, then clock the DUT.
  task automatic tick();
    if (!stall) begin
      if (clear) begin
        mdl_reset();
      end else if (set_flags) begin
        m_nzcv  = ref_nzcv(a, b, subtract);
        m_valid = 1'b1;
        if (m_cnt < 255) m_cnt = m_cnt + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub,
                       input logic sf, input logic st, input logic cl);
    a = x; b = y; subtract = sub; set_flags = sf; stall = st; clear = cl;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if (obs !== 13'h0) begin
      n_bad++;
      $display("FAIL reset_state: got %h want %h", obs, 13'h0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    mdl_reset();
  endtask

  task automatic test_directed();
    drive(64'd5, 64'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if (obs !== {4'b0110, 1'b1, 8'd1}) begin
      n_bad++;
      $display("FAIL sub_equal: got %h want %h", obs, {4'b0110, 1'b1, 8'd1});
    end
    drive(64'd3, 64'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (result !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      n_bad++;
      $display("FAIL sub_neg_result: got %h want %h", result, 64'hFFFF_FFFF_FFFF_FFFE);
    end
    n_cmp++;
    if (obs !== {4'b0110, 1'b1, 8'd1}) begin
      n_bad++;
      $display("FAIL same_cycle_old: got %h want %h", obs, {4'b0110, 1'b1, 8'd1});
    end
    tick();
    n_cmp++;
    if (obs !== {4'b1000, 1'b1, 8'd2}) begin
      n_bad++;
      $display("FAIL sub_borrow: got %h want %h", obs, {4'b1000, 1'b1, 8'd2});
    end
    drive(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if (obs !== {4'b1001, 1'b1, 8'd3}) begin
      n_bad++;
      $display("FAIL add_ovf: got %h want %h", obs, {4'b1001, 1'b1, 8'd3});
    end
    drive(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (result !== 64'd0) begin
      n_bad++;
      $display("FAIL add_wrap_result: got %h want %h", result, 64'd0);
    end
    tick();
    n_cmp++;
    if (obs !== {4'b0110, 1'b1, 8'd4}) begin
      n_bad++;
      $display("FAIL add_carry: got %h want %h", obs, {4'b0110, 1'b1, 8'd4});
    end
  endtask

  task automatic test_stall_hold();
    logic [12:0] snap;
    drive(64'd3, 64'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    snap = obs;
    n_cmp++;
    if (negative !== 1'b1) begin
      n_bad++;
      $display("FAIL hold_setup_n: got %b want %b", negative, 1'b1);
    end
    drive(64'd5, 64'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    n_cmp++;
    if (obs !== snap) begin
      n_bad++;
      $display("FAIL stall_hold: got %h want %h", obs, snap);
    end
    drive(64'd9, 64'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if (obs !== snap) begin
      n_bad++;
      $display("FAIL noset_hold: got %h want %h", obs, snap);
    end
    drive(64'd9, 64'd1, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    n_cmp++;
    if (obs !== snap) begin
      n_bad++;
      $display("FAIL stalled_clear: got %h want %h", obs, snap);
    end
  endtask

  task automatic test_clear_and_saturate();
    drive(64'd1, 64'd2, 1'b0, 1'b1, 1'b1, 1'b1);
    stall = 1'b0;
    tick();
    n_cmp++;
    if (obs !== 13'h0) begin
      n_bad++;
      $display("FAIL clear_priority: got %h want %h", obs, 13'h0);
    end
    for (int i = 0; i < 300; i++) begin
      drive({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'b1, 1'b0, 1'b0);
      tick();
      if (i == 254) begin
        n_cmp++;
        if (write_count !== 8'd255) begin
          n_bad++;
          $display("FAIL count_at_255: got %0d want %0d", write_count, 255);
        end
      end
    end
    n_cmp++;
    if (obs !== mdl_vec() || write_count !== 8'd255) begin
      n_bad++;
      $display("FAIL count_saturate: got %h want %h", obs, mdl_vec());
    end
  endtask

  task automatic test_async_reset();
    drive(64'd10, 64'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (obs !== 13'h0) begin
      n_bad++;
      $display("FAIL async_reset: got %h want %h", obs, 13'h0);
    end
    #1 reset = 1'b0;
    mdl_reset();
    drive(64'd2, 64'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if (obs !== {ref_nzcv(64'd2, 64'd7, 1'b1), 1'b1, 8'd1} || obs !== mdl_vec()) begin
      n_bad++;
      $display("FAIL post_reset_commit: got %h want %h", obs, mdl_vec());
    end
  endtask

  task automatic test_random();
    logic [W-1:0] edges [4];
    edges[0] = '0;
    edges[1] = '1;
    edges[2] = 64'h7FFF_FFFF_FFFF_FFFF;
    edges[3] = 64'h8000_0000_0000_0000;
    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : {$urandom, $urandom};
      b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) b = a;
      subtract  = 1'($urandom);
      set_flags = ($urandom_range(0, 1) == 0);
      stall     = ($urandom_range(0, 4) == 0);
      clear     = ($urandom_range(0, 19) == 0);
      #1;
      n_cmp++;
      if (result !== ref_result(a, b, subtract)) begin
        n_bad++;
        $display("FAIL rand_result[%0d]: got %h want %h", i, result, ref_result(a, b, subtract));
      end
      tick();
      n_cmp++;
      if (obs !== mdl_vec()) begin
        n_bad++;
        $display("FAIL rand_state[%0d]: got %h want %h", i, obs, mdl_vec());
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    drive('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    mdl_reset();
    test_reset();
    test_directed();
    test_stall_hold();
    test_clear_and_saturate();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
